// File: rtl/reg_file16_pkg.sv
// Shared definitions for the CR16 register file and the decoder.
// Contents: register geometry constants, the register-address type,
// register name constants R0..R15, and a 4->16 one-hot decode helper
// used for both the write-enable decode and the scoreboard set/clear masks.
package reg_file16_pkg;

  localparam int REG_W      = 16;
  localparam int REG_CNT    = 16;
  localparam int REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t R0  = 4'd0;
  localparam reg_addr_t R1  = 4'd1;
  localparam reg_addr_t R2  = 4'd2;
  localparam reg_addr_t R3  = 4'd3;
  localparam reg_addr_t R4  = 4'd4;
  localparam reg_addr_t R5  = 4'd5;
  localparam reg_addr_t R6  = 4'd6;
  localparam reg_addr_t R7  = 4'd7;
  localparam reg_addr_t R8  = 4'd8;
  localparam reg_addr_t R9  = 4'd9;
  localparam reg_addr_t R10 = 4'd10;
  localparam reg_addr_t R11 = 4'd11;
  localparam reg_addr_t R12 = 4'd12;
  localparam reg_addr_t R13 = 4'd13;
  localparam reg_addr_t R14 = 4'd14;
  localparam reg_addr_t R15 = 4'd15;

  // One-hot select of register 'addr', gated by 'en' (all zero when en=0).
  function automatic logic [REG_CNT-1:0] decode_onehot(input reg_addr_t addr,
                                                       input logic en);
    logic [REG_CNT-1:0] oh;
    oh = 16'h0001 << addr;
    if (en) begin
      return oh;
    end else begin
      return 16'h0000;
    end
  endfunction

endpackage

// File: rtl/reg_file16_if.sv
// Bus between decode/write-back (master) and the register file (slave).
// Signals: write-back port (wr_en/wr_addr/wr_data), two read ports
// (rd_addr_x -> rd_data_x), issue port (iss_en/iss_addr) and the scoreboard
// status outputs busy_a, busy_b, stall.
interface reg_file16_if;
  import reg_file16_pkg::*;

  logic             wr_en;
  reg_addr_t        wr_addr;
  logic [REG_W-1:0] wr_data;
  reg_addr_t        rd_addr_a;
  reg_addr_t        rd_addr_b;
  logic [REG_W-1:0] rd_data_a;
  logic [REG_W-1:0] rd_data_b;
  logic             iss_en;
  reg_addr_t        iss_addr;
  logic             busy_a;
  logic             busy_b;
  logic             stall;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, iss_en, iss_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, stall
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, iss_en, iss_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, stall
  );

endinterface

// File: rtl/reg_file16_mux16_1.sv
// Single-bit 16:1 read selector; one instance per data bit per read port.
// Ports: d (bit i of all 16 registers), sel (register address), y (selected bit).
module reg_file16_mux16_1
  import reg_file16_pkg::*;
(
  input  logic [REG_CNT-1:0] d,
  input  reg_addr_t          sel,
  output logic               y
);

  assign y = d[sel];

endmodule

// File: rtl/reg_file16_scoreboard.sv
// Per-register pending scoreboard for in-flight multi-cycle (load) ops.
// Ports: clk, rst_n (sync, active-low), write-back strobe/address (clears),
// issue strobe/address (sets), read addresses, and busy_a/busy_b/stall.
// A write to a register in the same cycle as an issue to it leaves the bit
// set: the new issue is younger than the retiring write.
module reg_file16_scoreboard
  import reg_file16_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  logic      iss_en,
  input  reg_addr_t iss_addr,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  output logic      busy_a,
  output logic      busy_b,
  output logic      stall
);

  localparam logic BYP = (BYPASS != 0);

  logic [REG_CNT-1:0] pending_r;
  logic [REG_CNT-1:0] set_s;
  logic [REG_CNT-1:0] clr_s;

  assign set_s = decode_onehot(iss_addr, iss_en);
  assign clr_s = decode_onehot(wr_addr, wr_en);

  // Pending bits: set has priority over clear; reset discards all in-flight state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= {REG_CNT{1'b0}};
    end else begin
      pending_r <= set_s | (pending_r & ~clr_s);
    end
  end

  // Busy lookup; a same-cycle write to the read register is forwarded, so not busy.
  always_comb begin
    busy_a = pending_r[rd_addr_a];
    busy_b = pending_r[rd_addr_b];
    if (BYP && wr_en && (wr_addr == rd_addr_a)) begin
      busy_a = 1'b0;
    end else begin
      busy_a = pending_r[rd_addr_a];
    end
    if (BYP && wr_en && (wr_addr == rd_addr_b)) begin
      busy_b = 1'b0;
    end else begin
      busy_b = pending_r[rd_addr_b];
    end
    stall = busy_a | busy_b | (iss_en & pending_r[iss_addr]);
  end

endmodule

// File: rtl/reg_file16.sv
// 16 x 16-bit general-purpose register file for the CR16 datapath.
// Ports: clk, rst_n (sync, active-low), bus (reg_file16_if.slave) carrying
// one synchronous write port, two combinational read ports, the issue port
// and the scoreboard status (busy_a, busy_b, stall).
// All registers, including r0, are writable. With BYPASS=1 a read of the
// register being written this cycle returns wr_data.
module reg_file16
  import reg_file16_pkg::*;
#(
  parameter int WIDTH  = REG_W,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file16_if.slave  bus
);

  localparam logic BYP = (BYPASS != 0);

  logic [WIDTH-1:0]   regs_r [REG_CNT];
  logic [REG_CNT-1:0] wr_sel_s;
  logic [REG_CNT-1:0] col_s  [WIDTH];
  logic [WIDTH-1:0]   mux_a_s;
  logic [WIDTH-1:0]   mux_b_s;

  assign wr_sel_s = decode_onehot(bus.wr_addr, bus.wr_en);

  // Register array: reset clears everything and overrides a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_CNT; r++) begin
        regs_r[r] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int r = 0; r < REG_CNT; r++) begin
        if (wr_sel_s[r]) begin
          regs_r[r] <= bus.wr_data;
        end
      end
    end
  end

  // Bit-column slicing: column b holds bit b of every register.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar r = 0; r < REG_CNT; r++) begin : g_reg
      assign col_s[b][r] = regs_r[r][b];
    end

    reg_file16_mux16_1 u_mux_a (
      .d   (col_s[b]),
      .sel (bus.rd_addr_a),
      .y   (mux_a_s[b])
    );

    reg_file16_mux16_1 u_mux_b (
      .d   (col_s[b]),
      .sel (bus.rd_addr_b),
      .y   (mux_b_s[b])
    );
  end

  // Write-to-read forwarding after the selectors.
  always_comb begin
    if (BYP && bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
      bus.rd_data_a = bus.wr_data;
    end else begin
      bus.rd_data_a = mux_a_s;
    end
    if (BYP && bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
      bus.rd_data_b = bus.wr_data;
    end else begin
      bus.rd_data_b = mux_b_s;
    end
  end

  reg_file16_scoreboard #(
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .iss_en    (bus.iss_en),
    .iss_addr  (bus.iss_addr),
    .rd_addr_a (bus.rd_addr_a),
    .rd_addr_b (bus.rd_addr_b),
    .busy_a    (bus.busy_a),
    .busy_b    (bus.busy_b),
    .stall     (bus.stall)
  );

endmodule
